// File: rtl/rom_disp_pkg.sv
// Shared definitions for the 7-segment display path: frame geometry, shifter states and
// the frame-word bit order used by both the scan driver and the 595 serialiser.
package rom_disp_pkg;

    localparam int unsigned SEL_W   = 6;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned FRAME_W = SEL_W + SEG_W;

    typedef enum logic [1:0] {
        StLoad,
        StShift,
        StLatch
    } shift_state_e;

    // Bit 0 leaves the shifter first, so seg[0] lands in the far 595 and sel[5] in the near one.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [SEL_W-1:0] sel,
                                                      input logic [SEG_W-1:0] seg);
        return {sel, seg};
    endfunction

endpackage

// File: rtl/hc595_frame_shifter.sv
// Serialises the digit-select and segment pattern into two cascaded 74HC595s, one frame
// after another: sample inputs, shift FRAME_W bits, pulse the storage clock.
module hc595_frame_shifter
    import rom_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FRAME_W = rom_disp_pkg::FRAME_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEG_W-1:0] seg,
    output logic             frame_done,
    output logic             stcp,
    output logic             shcp,
    output logic             ds,
    output logic             oe
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [3:0]      BitLast = 4'(FRAME_W - 1);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("hc595_frame_shifter: CLK_DIV must be even and >= 2");
    end
    if (FRAME_W != SEL_W + SEG_W) begin : g_bad_frame_w
        $error("hc595_frame_shifter: FRAME_W must equal SEL_W + SEG_W");
    end

    shift_state_e        state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          k_q, k_d;
    logic [FRAME_W-1:0]  word_q, word_d;

    logic stcp_q, stcp_d;
    logic shcp_q, shcp_d;
    logic ds_q, ds_d;
    logic oe_q, oe_d;
    logic frame_done_q, frame_done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        word_d  = word_q;
        unique case (state_q)
            StLoad: begin
                word_d  = pack_frame(sel, seg);
                cnt_d   = '0;
                k_d     = '0;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (k_q == BitLast) begin
                        state_d = StLatch;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StLatch: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Pin values are decoded from the next state so the registered pins line up with the
    // state they describe rather than trailing it by a cycle.
    always_comb begin
        shcp_d       = (state_d == StShift) && (cnt_d >= CntHalf);
        stcp_d       = (state_d == StLatch) && (cnt_d >= CntHalf);
        frame_done_d = (state_d == StLatch) && (cnt_d == CntLast);
        ds_d         = ds_q;
        if (state_d == StShift) begin
            ds_d = word_d[k_d];
        end else if (state_d == StLatch) begin
            ds_d = word_d[FRAME_W-1];
        end
        // Display stays blanked until a complete frame has reached the storage registers.
        oe_d = oe_q && !frame_done_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            k_q          <= '0;
            word_q       <= '0;
            stcp_q       <= 1'b0;
            shcp_q       <= 1'b0;
            ds_q         <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            word_q       <= word_d;
            stcp_q       <= stcp_d;
            shcp_q       <= shcp_d;
            ds_q         <= ds_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign stcp       = stcp_q;
    assign shcp       = shcp_q;
    assign ds         = ds_q;
    assign oe         = oe_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_frame_shifter.sv
// Bench for hc595_frame_shifter at CLK_DIV=4: per-cycle pin timing model plus a scoreboard
// of frame bits pushed when the DUT samples its inputs and popped on each shcp rise.
module tb_hc595_frame_shifter;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned FRAME_W   = 14;
    localparam int unsigned HALF      = CLK_DIV / 2;
    localparam int unsigned SHIFT_CYC = FRAME_W * CLK_DIV;
    localparam int unsigned PERIOD    = 1 + 15 * CLK_DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [5:0] sel = 6'b000001;
    logic [7:0] seg = 8'hC0;
    logic       frame_done, stcp, shcp, ds, oe;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    hc595_frame_shifter #(
        .CLK_DIV (CLK_DIV),
        .FRAME_W (FRAME_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done),
        .stcp       (stcp),
        .shcp       (shcp),
        .ds         (ds),
        .oe         (oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_stcp"}, {31'd0, stcp}, 0);
        check({tag, "_shcp"}, {31'd0, shcp}, 0);
        check({tag, "_ds"}, {31'd0, ds}, 0);
        check({tag, "_oe"}, {31'd0, oe}, 1);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    endtask

    // Monitor state; cyc counts rising edges since reset release.
    bit          q[$];
    int          cyc = 0;
    int          fd_count = 0;
    int          last_fd_c, last_rise_c, last_dschg_c;
    int          mc, mpos;
    logic        prev_shcp, prev_ds, exp_bit;
    logic [13:0] mword;

    always @(posedge sys_clk) begin
        #1;
        if (!sys_rst_n) begin
            q.delete();
            cyc          = 0;
            last_fd_c    = 0;
            last_rise_c  = 0;
            last_dschg_c = 0;
            prev_shcp    = 1'b0;
            prev_ds      = 1'b0;
        end else begin
            cyc++;
            // This edge closes a LOAD cycle: the DUT just captured sel/seg.
            if ((cyc - 1) % PERIOD == 0) begin
                mword = {sel, seg};
                for (int i = 0; i < FRAME_W; i++) q.push_back(mword[i]);
            end
            mc   = cyc + 1;
            mpos = (mc - 1) % PERIOD;
            check("shcp_timing", {31'd0, shcp},
                  {31'd0, (mpos >= 1 && mpos <= SHIFT_CYC && ((mpos - 1) % CLK_DIV) >= HALF)});
            check("stcp_timing", {31'd0, stcp},
                  {31'd0, (mpos > SHIFT_CYC && (mpos - 1 - SHIFT_CYC) >= HALF)});
            check("frame_done_timing", {31'd0, frame_done}, {31'd0, (mpos == PERIOD - 1)});
            check("oe", {31'd0, oe}, {31'd0, (mc <= PERIOD)});
            if (stcp) check("shcp_low_in_latch", {31'd0, shcp}, 0);
            if (ds !== prev_ds) begin
                if (last_rise_c > 0) check("ds_hold", {31'd0, (mc - last_rise_c >= HALF)}, 1);
                last_dschg_c = mc;
            end
            if (shcp && !prev_shcp) begin
                check("ds_setup", {31'd0, (mc - last_dschg_c >= HALF)}, 1);
                check("sb_avail", {31'd0, (q.size() != 0)}, 1);
                if (q.size() != 0) begin
                    exp_bit = q.pop_front();
                    check("ds_bit", {31'd0, ds}, {31'd0, exp_bit});
                end
                last_rise_c = mc;
            end
            if (frame_done) begin
                check("sb_drained", q.size(), 0);
                if (last_fd_c > 0) check("fd_interval", mc - last_fd_c, PERIOD);
                last_fd_c = mc;
                fd_count++;
            end
            prev_shcp = shcp;
            prev_ds   = ds;
        end
    end

    int fd0;

    initial begin
        repeat (3) @(negedge sys_clk);
        check_reset("por");

        // Frame of C0/000001, seg changed mid-shift, three frames total.
        sys_rst_n = 1'b1;
        while (cyc < 19) @(negedge sys_clk);
        seg = 8'hF9;
        fd0 = fd_count;
        while (cyc < 3 * PERIOD + 3) @(negedge sys_clk);
        check("frames_a", fd_count - fd0, 3);

        // Fresh start, then an asynchronous reset in the middle of the second frame.
        sys_rst_n = 1'b0;
        #1 check_reset("rst_b");
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        fd0 = fd_count;
        while (cyc < 99) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset("rst_mid");
        check("frames_b0", fd_count - fd0, 1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        fd0 = fd_count;
        while (cyc < PERIOD + 3) @(negedge sys_clk);
        check("frames_b1", fd_count - fd0, 1);

        // All-ones segments with the last digit selected, ten frames.
        sys_rst_n = 1'b0;
        sel = 6'b100000;
        seg = 8'hFF;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        fd0 = fd_count;
        while (cyc < 10 * PERIOD + 2) @(negedge sys_clk);
        check("frames_c", fd_count - fd0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
